muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports.
//  - Operands: RD1 -> op_a, RD2 -> op_b.
//  - Result and destination address are written back through the register file write port (WD3/A3/WE3).
//  - Uses one shift-add / restoring-divide datapath, one bit per cycle, with a start/busy/done handshake.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_unit_operand_prep.sv | 51 +++++
 rtl/muldiv_unit.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Contents: default operand width, funct3 encodings, FSM state encoding
// and the is_div() helper used by the operand prep and the FSM.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Every divide/remainder encoding has funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_unit_operand_prep.sv
// Combinational operand preparation for muldiv_unit.
// Converts the raw register values to magnitudes according to the
// signedness of the selected operation and flags the divide special cases.
// Ports:
//   funct3       in   operation select
//   op_a, op_b   in   raw rs1 / rs2 values
//   a_mag, b_mag out  absolute values (unchanged for unsigned operands)
//   sign_a       out  op_a is treated as negative
//   sign_b       out  op_b is treated as negative
//   div_by_zero  out  divide/remainder with op_b == 0
//   div_overflow out  signed -2^(XLEN-1) / -1
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            sign_a,
    output logic            sign_b,
    output logic            div_by_zero,
    output logic            div_overflow
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic a_signed;
    logic b_signed;

    always_comb begin
        // MUL only keeps the low half, which is identical for either
        // signedness, so it shares the signed path.
        a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU)
                || (funct3 == F3_DIV) || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH)
                || (funct3 == F3_DIV) || (funct3 == F3_REM);

        sign_a = a_signed & op_a[XLEN-1];
        sign_b = b_signed & op_b[XLEN-1];
        a_mag  = sign_a ? -op_a : op_a;
        b_mag  = sign_b ? -op_b : op_b;

        div_by_zero  = is_div(funct3) && (op_b == '0);
        div_overflow = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                    && (op_a == MIN_NEG) && (op_b == '1);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit fed from the register file read
// ports; result goes back through the write port (WD3/A3/WE3).
// One shift-add / restoring-divide step per cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN -- multiplies use a single
// combinational multiplier and bypass CALC; divides are unaffected.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start, kill    launch (ignored while busy) / abort in-flight op
//   funct3         operation select (MUL..REMU)
//   op_a, op_b     rs1 / rs2 values, captured when start is accepted
//   rd_in          destination register, captured when start is accepted
//   busy           high from the cycle after accept through the done cycle
//   done           one-cycle result-valid pulse
//   we_out         done with a non-zero destination (WE3)
//   rd_out         captured destination (A3)
//   result         last completed result (WD3)
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | one datapath step per cycle, counter XLEN-1 down to 0
// S_FIX  | apply result signs and divide special cases
// S_DONE | result valid, done pulse
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            we_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;       // product, or remainder:quotient
    logic [XLEN-1:0]   opd_q, opd_d;       // multiplicand or divisor magnitude
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   a_mag, b_mag;
    logic              sign_a, sign_b, div_by_zero, div_overflow;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .a_mag        (a_mag),
        .b_mag        (b_mag),
        .sign_a       (sign_a),
        .sign_b       (sign_b),
        .div_by_zero  (div_by_zero),
        .div_overflow (div_overflow)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quot_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   fix_value;

    always_comb begin : datapath
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        // Partial remainder stays below the divisor, so the shifted trial
        // fits in XLEN+1 bits and bit XLEN of the difference is a clean borrow.
        // With a zero divisor the upper half simply collects op_a, which is
        // exactly the remainder required for that case.
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, opd_q};

        prod_signed = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot_signed = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_signed  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (f3_q)
            F3_MUL:                       fix_value = prod_signed[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_value = prod_signed[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_value = dz_q ? '1 : (ovf_q ? MIN_NEG : quot_signed);
            F3_REM, F3_REMU:              fix_value = ovf_q ? '0 : rem_signed;
            default:                      fix_value = '0;
        endcase
    end

    always_comb begin : fsm
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        rd_d     = rd_q;
        result_d = result_q;

        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f3_d    = funct3;
                        sa_d    = sign_a;
                        sb_d    = sign_b;
                        dz_d    = div_by_zero;
                        ovf_d   = div_overflow;
                        rd_d    = rd_in;
                        cnt_d   = CNT_LAST;
                        state_d = S_CALC;
                        if (is_div(funct3)) begin
                            acc_d = {{XLEN{1'b0}}, a_mag};
                            opd_d = b_mag;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, b_mag};
                            opd_d = a_mag;
`ifdef MULDIV_FAST_MUL_EN
                            acc_d   = fast_prod;
                            state_d = S_FIX;
`endif
                        end
                    end
                end
                S_CALC: begin
                    if (is_div(f3_q)) begin
                        if (!div_diff[XLEN]) begin
                            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    result_d = fix_value;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign we_out = done & (rd_q != '0);
    assign rd_out = rd_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an arithmetic reference model
// tracks the expected busy/done/result timeline, a compare process checks
// it every cycle, and directed operations pin literal results and latency.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        we_out;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .we_out (we_out),
        .rd_out (rd_out),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Arithmetic reference from the RV32M definitions.
    function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        p  = '0;
        r  = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Cycles from the start edge to the edge that samples done high.
    function automatic int lat(input logic [2:0] f);
`ifdef MULDIV_FAST_MUL_EN
        return (f < 3'd4) ? 2 : 34;
`else
        return (f < 3'd4) ? 34 : 34;
`endif
    endfunction

    // Behavioural model of the handshake timeline.
    bit          m_busy   = 0;
    bit          m_done   = 0;
    int          m_left   = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_exp    = '0;
    logic [4:0]  m_rd     = '0;
    bit          chk_en   = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_left = 0; m_result = '0; m_rd = '0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            if (kill) begin
                m_busy = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done   = 1;
                    m_result = m_exp;
                end
            end
        end else if (start && !kill) begin
            m_busy = 1;
            m_exp  = ref_calc(funct3, op_a, op_b);
            m_rd   = rd_in;
            m_left = lat(funct3) - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("we_out", we_out, m_done && (m_rd != 0));
            check("result", result, m_result);
            if (m_done) check("rd_out", rd_out, m_rd);
        end
    end

    // Caller is at a negedge with the unit idle; returns at the first idle
    // negedge after done so the next call starts back-to-back.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit has_lit, input logic [31:0] lit,
                         input string nm);
        int cyc;
        if (has_lit) check({nm, " model"}, ref_calc(f, a, b), lit);
        start = 1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(negedge clk);
        start = 0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, cyc, lat(f));
        if (has_lit) check({nm, " result"}, result, lit);
        check({nm, " we_out"}, we_out, rd != 0);
        check({nm, " rd_out"}, rd_out, rd);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;

        reset = 1; start = 0; kill = 0; funct3 = 0; op_a = 0; op_b = 0; rd_in = 0;
        repeat (3) @(negedge clk);
        reset  = 0;
        chk_en = 1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset we_out", we_out, 0);
        check("reset rd_out", rd_out, 0);
        check("reset result", result, 0);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1, 32'hFFFF_FFEB, "mul_7x-3");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1, 32'h4000_0000, "mulh_min");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1, 32'hFFFF_FFFE, "mulhu_max");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1, 32'hFFFF_FFFF, "mulhsu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1, 32'hFFFF_FFFD, "div_-7/2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1, 32'hFFFF_FFFF, "rem_-7/2");
        do_op(3'd5, 32'd100, 32'd7, 5'd7, 1, 32'd14, "divu_100/7");
        do_op(3'd7, 32'd100, 32'd7, 5'd8, 1, 32'd2, "remu_100/7");
        do_op(3'd4, 32'd5, 32'd0, 5'd9, 1, 32'hFFFF_FFFF, "div_by0");
        do_op(3'd7, 32'd5, 32'd0, 5'd10, 1, 32'd5, "remu_by0");
        do_op(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd11, 1, 32'hFFFF_FFFB, "rem_neg_by0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, 32'h8000_0000, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 32'd0, "rem_ovf");
        do_op(3'd0, 32'd6, 32'd9, 5'd0, 1, 32'd54, "mul_rd0");
        do_op(3'd5, 32'd100, 32'd7, 5'd14, 1, 32'd14, "back2back");

        // Second start mid-operation must be ignored.
        start = 1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        start = 1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd9;
        @(negedge clk);
        start = 0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("restart dones", n, 1);
        check("restart result", result, 32'd14);

        // Kill mid-operation: no done, result held.
        start = 1; funct3 = 3'd4; op_a = 32'hFFFF_FF9C; op_b = 32'd7; rd_in = 5'd4;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        kill = 1;
        @(negedge clk);
        kill = 0;
        check("kill busy", busy, 0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("kill dones", n, 0);
        check("kill result held", result, 32'd14);

        // Reset mid-operation.
        start = 1; funct3 = 3'd1; op_a = 32'h1234_5678; op_b = 32'h8765_4321; rd_in = 5'd17;
        @(negedge clk);
        start = 0;
        repeat (14) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset we_out", we_out, 0);
        check("midreset rd_out", rd_out, 0);
        check("midreset result", result, 0);
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1, 32'hFFFF_FFEB, "after_reset_mul");

        for (int i = 0; i < 120; i++) begin
            f  = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 5))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
                3: begin a = -$urandom_range(0, 200); b = $urandom_range(1, 20); end
                default: ;
            endcase
            do_op(f, a, b, rd, 0, 32'd0, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
